// File: rtl/serial_bus_arbiter_if.sv
// ---------------------------------------------------------------------------
// serial_bus_arbiter_if
// Purpose : bundles the per-master serial request lines, the shared slave bus
//           and the arbiter status outputs between NM masters and one slave.
// Ports   : NM parameter sets the master count.
//   req/m_*            per-master request and serial bus lines (NM bits each)
//   s_*                muxed lines toward the slave
//   s_ready/s_valid_out/s_data_out/s_hold  slave returns
//   m_ready/m_rvalid/m_rdata               returns gated to the owner
//   grant/owner/bus_busy/timeout_err       arbitration status
// Modports: slave  = arbiter side (serves the masters, drives the slave bus)
//           master = environment side (masters plus the bit-serial slave)
// ---------------------------------------------------------------------------
interface serial_bus_arbiter_if #(
    parameter int unsigned NM = 3
);
    localparam int unsigned OW = (NM > 1) ? $clog2(NM) : 1;

    logic [NM-1:0] req;
    logic [NM-1:0] m_valid;
    logic [NM-1:0] m_wren;
    logic [NM-1:0] m_addr;
    logic [NM-1:0] m_data;
    logic [NM-1:0] m_burst;

    logic          s_valid;
    logic          s_wren;
    logic          s_addr;
    logic          s_data;
    logic          s_burst;

    logic          s_ready;
    logic          s_valid_out;
    logic          s_data_out;
    logic          s_hold;

    logic [NM-1:0] m_ready;
    logic [NM-1:0] m_rvalid;
    logic [NM-1:0] m_rdata;

    logic [NM-1:0] grant;
    logic [OW-1:0] owner;
    logic          bus_busy;
    logic          timeout_err;

    modport slave (
        input  req, m_valid, m_wren, m_addr, m_data, m_burst,
        input  s_ready, s_valid_out, s_data_out, s_hold,
        output s_valid, s_wren, s_addr, s_data, s_burst,
        output m_ready, m_rvalid, m_rdata,
        output grant, owner, bus_busy, timeout_err
    );

    modport master (
        output req, m_valid, m_wren, m_addr, m_data, m_burst,
        output s_ready, s_valid_out, s_data_out, s_hold,
        input  s_valid, s_wren, s_addr, s_data, s_burst,
        input  m_ready, m_rvalid, m_rdata,
        input  grant, owner, bus_busy, timeout_err
    );
endinterface

// File: rtl/serial_bus_arbiter.sv
// ---------------------------------------------------------------------------
// serial_bus_arbiter
// Purpose : round-robin arbiter sharing one bit-serial slave among NM masters,
//           with a per-grant timeout that ignores slave hold cycles.
// Ports   :
//   clk    system clock, rising edge
//   reset  asynchronous active-high reset
//   bus    serial_bus_arbiter_if.slave (requests, muxed bus, returns, status)
// ---------------------------------------------------------------------------
module serial_bus_arbiter #(
    parameter int unsigned NM      = 3,
    parameter int unsigned TIMEOUT = 1024
) (
    input  logic                 clk,
    input  logic                 reset,
    serial_bus_arbiter_if.slave  bus
);
    localparam int unsigned OW = (NM > 1) ? $clog2(NM) : 1;
    localparam int unsigned TW = $clog2(TIMEOUT) + 1;
    localparam logic [TW-1:0] TLAST = TW'(TIMEOUT - 1);
    localparam logic [OW-1:0] OLAST = OW'(NM - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        TURN = 2'd2
    } state_t;

    state_t        state;
    logic [NM-1:0] grant_q;
    logic [OW-1:0] owner_q;
    logic [OW-1:0] ptr;
    logic [TW-1:0] timer;
    logic          busy_q;
    logic          terr_q;
    logic [OW-1:0] win;

    // First requester found scanning from ptr upward, wrapping at NM.
    function automatic logic [OW-1:0] rr_pick(input logic [NM-1:0] r,
                                              input logic [OW-1:0] p);
        logic [OW-1:0] w;
        logic [OW-1:0] k;
        logic          found;
        w     = p;
        found = 1'b0;
        for (int unsigned i = 0; i < NM; i++) begin
            k = OW'((32'(p) + i) % NM);
            if (!found && r[k]) begin
                w     = k;
                found = 1'b1;
            end
        end
        return w;
    endfunction

    assign win = rr_pick(bus.req, ptr);

    // Arbitration FSM with registered grant/owner/status.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            grant_q <= '0;
            owner_q <= '0;
            ptr     <= '0;
            timer   <= '0;
            busy_q  <= 1'b0;
            terr_q  <= 1'b0;
        end else begin
            terr_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (|bus.req) begin
                        grant_q <= NM'(1) << win;
                        owner_q <= win;
                        timer   <= '0;
                        busy_q  <= 1'b1;
                        state   <= BUSY;
                    end
                end
                BUSY: begin
                    // A dropped request wins over a coincident timeout.
                    if (!bus.req[owner_q] || (!bus.s_hold && timer == TLAST)) begin
                        grant_q <= '0;
                        busy_q  <= 1'b0;
                        ptr     <= (owner_q == OLAST) ? '0 : owner_q + OW'(1);
                        terr_q  <= bus.req[owner_q];
                        state   <= TURN;
                    end else if (!bus.s_hold) begin
                        timer <= timer + TW'(1);
                    end
                end
                TURN: begin
                    state <= IDLE;
                end
                default: begin
                    state   <= IDLE;
                    grant_q <= '0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    // Grant is one-hot or zero, so AND-OR reduction is the owner mux.
    assign bus.s_valid  = |(grant_q & bus.m_valid);
    assign bus.s_wren   = |(grant_q & bus.m_wren);
    assign bus.s_addr   = |(grant_q & bus.m_addr);
    assign bus.s_data   = |(grant_q & bus.m_data);
    assign bus.s_burst  = |(grant_q & bus.m_burst);

    assign bus.m_ready  = grant_q & {NM{bus.s_ready}};
    assign bus.m_rvalid = grant_q & {NM{bus.s_valid_out}};
    assign bus.m_rdata  = grant_q & {NM{bus.s_data_out}};

    assign bus.grant       = grant_q;
    assign bus.owner       = owner_q;
    assign bus.bus_busy    = busy_q;
    assign bus.timeout_err = terr_q;
endmodule

// File: tb/tb_serial_bus_arbiter.sv
// ---------------------------------------------------------------------------
// tb_serial_bus_arbiter
// Purpose : self-checking bench for serial_bus_arbiter (NM=3, TIMEOUT=16):
//           a vector table for grant/mux/gating, then hand sequences for
//           async reset, fairness, timeout, hold freeze and release/timeout.
// ---------------------------------------------------------------------------
module tb_serial_bus_arbiter;
    localparam int unsigned NM = 3;
    localparam int unsigned TO = 16;

    logic clk;
    logic reset;
    int   checks;
    int   failures;

    serial_bus_arbiter_if #(.NM(NM)) bus ();

    serial_bus_arbiter #(.NM(NM), .TIMEOUT(TO)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic [2:0] req, mv, mw, ma, md, mb;
        logic [3:0] sin;          // {s_ready, s_valid_out, s_data_out, s_hold}
        logic [2:0] eg;
        logic [1:0] eo;
        logic       eb;
        logic [4:0] es;           // {s_valid, s_wren, s_addr, s_data, s_burst}
        logic [2:0] er, erv, erd;
    } vec_t;

    function automatic vec_t mk(input logic [2:0] req, mv, mw, ma, md, mb,
                                input logic [3:0] sin,
                                input logic [2:0] eg, input logic [1:0] eo,
                                input logic eb, input logic [4:0] es,
                                input logic [2:0] er, erv, erd);
        vec_t v;
        v.req = req; v.mv = mv; v.mw = mw; v.ma = ma; v.md = md; v.mb = mb;
        v.sin = sin; v.eg = eg; v.eo = eo; v.eb = eb; v.es = es;
        v.er = er; v.erv = erv; v.erd = erd;
        return v;
    endfunction

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [4:0] s_bus();
        return {bus.s_valid, bus.s_wren, bus.s_addr, bus.s_data, bus.s_burst};
    endfunction

    task automatic chk_quiet(input string name);
        check({name, " grant"}, 8'(bus.grant), 8'h0);
        check({name, " owner"}, 8'(bus.owner), 8'h0);
        check({name, " busy"}, 8'(bus.bus_busy), 8'h0);
        check({name, " terr"}, 8'(bus.timeout_err), 8'h0);
        check({name, " s_bus"}, 8'(s_bus()), 8'h0);
        check({name, " m_ret"}, 8'({bus.m_ready, bus.m_rvalid}), 8'h0);
        check({name, " m_rdata"}, 8'(bus.m_rdata), 8'h0);
    endtask

    task automatic drive_all(input logic [2:0] v, input logic sv);
        bus.m_valid = v; bus.m_wren = v; bus.m_addr = v; bus.m_data = v; bus.m_burst = v;
        bus.s_ready = sv; bus.s_valid_out = sv; bus.s_data_out = sv;
    endtask

    vec_t vt [12];
    int   cnt;
    int   n;
    int   own;
    int   gap;
    int   ngr;
    logic [2:0] prev;
    logic [2:0] fseq [4];

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        checks   = 0;
        failures = 0;
        reset    = 1'b1;
        bus.req  = '0;
        bus.s_hold = 1'b0;
        drive_all(3'b000, 1'b0);

        vt[0]  = mk(3'b010, 3'b010, 3'b000, 3'b010, 3'b000, 3'b000, 4'b1010,
                    3'b010, 2'd1, 1'b1, 5'b10100, 3'b010, 3'b000, 3'b010);
        vt[1]  = mk(3'b010, 3'b010, 3'b000, 3'b000, 3'b111, 3'b000, 4'b0100,
                    3'b010, 2'd1, 1'b1, 5'b10010, 3'b000, 3'b010, 3'b000);
        vt[2]  = mk(3'b010, 3'b111, 3'b101, 3'b111, 3'b000, 3'b010, 4'b1110,
                    3'b010, 2'd1, 1'b1, 5'b10101, 3'b010, 3'b010, 3'b010);
        vt[3]  = mk(3'b000, 3'b111, 3'b111, 3'b111, 3'b111, 3'b111, 4'b1110,
                    3'b000, 2'd1, 1'b0, 5'b00000, 3'b000, 3'b000, 3'b000);
        vt[4]  = mk(3'b101, 3'b111, 3'b111, 3'b111, 3'b111, 3'b111, 4'b1110,
                    3'b000, 2'd1, 1'b0, 5'b00000, 3'b000, 3'b000, 3'b000);
        vt[5]  = mk(3'b101, 3'b111, 3'b000, 3'b011, 3'b100, 3'b000, 4'b1000,
                    3'b100, 2'd2, 1'b1, 5'b10010, 3'b100, 3'b000, 3'b000);
        vt[6]  = mk(3'b001, 3'b111, 3'b111, 3'b111, 3'b111, 3'b111, 4'b1110,
                    3'b000, 2'd2, 1'b0, 5'b00000, 3'b000, 3'b000, 3'b000);
        vt[7]  = mk(3'b011, 3'b111, 3'b111, 3'b111, 3'b111, 3'b111, 4'b1110,
                    3'b000, 2'd2, 1'b0, 5'b00000, 3'b000, 3'b000, 3'b000);
        vt[8]  = mk(3'b011, 3'b111, 3'b000, 3'b000, 3'b000, 3'b000, 4'b0000,
                    3'b001, 2'd0, 1'b1, 5'b10000, 3'b000, 3'b000, 3'b000);
        vt[9]  = mk(3'b010, 3'b111, 3'b111, 3'b111, 3'b111, 3'b111, 4'b1110,
                    3'b000, 2'd0, 1'b0, 5'b00000, 3'b000, 3'b000, 3'b000);
        vt[10] = mk(3'b000, 3'b111, 3'b111, 3'b111, 3'b111, 3'b111, 4'b1110,
                    3'b000, 2'd0, 1'b0, 5'b00000, 3'b000, 3'b000, 3'b000);
        vt[11] = mk(3'b000, 3'b111, 3'b111, 3'b111, 3'b111, 3'b111, 4'b1110,
                    3'b000, 2'd0, 1'b0, 5'b00000, 3'b000, 3'b000, 3'b000);

        #2;
        chk_quiet("por");
        @(negedge clk);
        reset = 1'b0;

        // Table: single request, TURN re-request, pointer wrap.
        for (int i = 0; i < 12; i++) begin
            bus.req = vt[i].req;
            bus.m_valid = vt[i].mv; bus.m_wren = vt[i].mw; bus.m_addr = vt[i].ma;
            bus.m_data = vt[i].md;  bus.m_burst = vt[i].mb;
            {bus.s_ready, bus.s_valid_out, bus.s_data_out, bus.s_hold} = vt[i].sin;
            tick();
            check($sformatf("vec%0d grant", i), 8'(bus.grant), 8'(vt[i].eg));
            check($sformatf("vec%0d owner", i), 8'(bus.owner), 8'(vt[i].eo));
            check($sformatf("vec%0d busy", i), 8'(bus.bus_busy), 8'(vt[i].eb));
            check($sformatf("vec%0d terr", i), 8'(bus.timeout_err), 8'h0);
            check($sformatf("vec%0d s_bus", i), 8'(s_bus()), 8'(vt[i].es));
            check($sformatf("vec%0d m_ready", i), 8'(bus.m_ready), 8'(vt[i].er));
            check($sformatf("vec%0d m_rvalid", i), 8'(bus.m_rvalid), 8'(vt[i].erv));
            check($sformatf("vec%0d m_rdata", i), 8'(bus.m_rdata), 8'(vt[i].erd));
        end

        // Asynchronous reset mid-cycle while master 1 owns the bus.
        bus.req = 3'b010;
        drive_all(3'b010, 1'b1);
        tick();
        check("arst pre grant", 8'(bus.grant), 8'h2);
        #2;
        drive_all(3'b111, 1'b1);
        bus.req = 3'b111;
        #1;
        reset = 1'b1;
        drive_all(3'b101, 1'b1);
        #1;
        chk_quiet("arst");
        @(negedge clk);
        bus.req = '0;
        drive_all(3'b000, 1'b0);
        reset = 1'b0;

        // Fairness with all three requesting, each releasing after 5 cycles.
        fseq[0] = 3'b001; fseq[1] = 3'b010; fseq[2] = 3'b100; fseq[3] = 3'b001;
        prev = '0; own = 0; gap = 0; ngr = 0;
        for (int c = 0; c < 80 && ngr < 4; c++) begin
            if (bus.grant != 3'b000 && own == 5) bus.req = 3'b111 & ~bus.grant;
            else bus.req = 3'b111;
            tick();
            if (bus.grant == 3'b000) begin
                gap++;
            end else if (prev == 3'b000) begin
                check($sformatf("fair grant%0d", ngr), 8'(bus.grant), 8'(fseq[ngr]));
                if (ngr > 0) check($sformatf("fair gap%0d", ngr), 8'(gap), 8'd2);
                ngr++;
                gap = 0;
                own = 1;
            end else begin
                own++;
            end
            prev = bus.grant;
        end
        check("fair count", 8'(ngr), 8'd4);
        bus.req = '0;
        repeat (3) tick();

        // Timeout: master 0 holds past TIMEOUT while master 2 waits.
        @(negedge clk);
        reset = 1'b1;
        #1;
        reset = 1'b0;
        bus.req = 3'b101;
        n = 0;
        while (bus.grant != 3'b001 && n < 10) begin tick(); n++; end
        check("to grant0", 8'(bus.grant), 8'h1);
        cnt = 0; n = 0;
        while (bus.grant == 3'b001 && n < 60) begin
            if (bus.timeout_err) check("to early terr", 8'(bus.timeout_err), 8'h0);
            cnt++; tick(); n++;
        end
        check("to length", 8'(cnt), 8'd16);
        check("to terr pulse", 8'(bus.timeout_err), 8'h1);
        check("to busy low", 8'(bus.bus_busy), 8'h0);
        tick();
        check("to terr cleared", 8'(bus.timeout_err), 8'h0);
        check("to gap grant", 8'(bus.grant), 8'h0);
        tick();
        check("to next grant", 8'(bus.grant), 8'h4);
        check("to next owner", 8'(bus.owner), 8'h2);
        bus.req = '0;
        repeat (3) tick();

        // Hold freeze: 10 hold cycles extend the grant to 26 cycles.
        bus.req = 3'b001;
        n = 0;
        while (bus.grant != 3'b001 && n < 10) begin tick(); n++; end
        check("hold grant0", 8'(bus.grant), 8'h1);
        cnt = 0; n = 0;
        while (bus.grant == 3'b001 && n < 80) begin
            cnt++;
            bus.s_hold = (cnt >= 3 && cnt < 13);
            tick(); n++;
        end
        bus.s_hold = 1'b0;
        check("hold length", 8'(cnt), 8'd26);
        check("hold terr", 8'(bus.timeout_err), 8'h1);
        bus.req = '0;
        repeat (3) tick();

        // Request drops on the same edge the timer expires.
        bus.req = 3'b001;
        n = 0;
        while (bus.grant != 3'b001 && n < 10) begin tick(); n++; end
        check("rel grant0", 8'(bus.grant), 8'h1);
        cnt = 0; n = 0;
        while (bus.grant == 3'b001 && n < 40) begin
            cnt++;
            if (cnt == 16) bus.req = 3'b000;
            tick(); n++;
        end
        check("rel length", 8'(cnt), 8'd16);
        check("rel no terr", 8'(bus.timeout_err), 8'h0);
        check("rel grant low", 8'(bus.grant), 8'h0);
        tick();
        check("rel no terr later", 8'(bus.timeout_err), 8'h0);
        repeat (2) tick();
        chk_quiet("end idle");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/serial_bus_arbiter.md
# serial_bus_arbiter

Round-robin arbiter that shares the single bit-serial slave bus (the BRAM/UART bridge slave) among NM masters. Sits between the masters and the slave. Grants exclusive ownership to one requester and muxes that master's serial request lines onto the slave. Routes the slave's ready/read-data back only to the owner. Enforces a per-transaction timeout so a hung master cannot lock the bus.

## Interface
- NM, 3: number of masters (2..8).
- TIMEOUT, 1024: maximum owned cycles per grant, excluding cycles with s_hold=1.
- OW, $clog2(NM): owner index width.
- clk  in  1  system clock; all state on rising edge.
- reset  in  1  asynchronous, active-high; forces all state and outputs to reset values immediately.
- req  in  NM  per-master bus request; held high for the whole transaction.
- m_valid, m_wren, m_addr, m_data, m_burst  in  NM each  per-master serial validIn/wren/Address/DataIn/BurstEn.
- s_valid, s_wren, s_addr, s_data, s_burst  out  1 each  muxed to slave; 0 when no grant.
- s_ready, s_validOut, s_dataOut, s_hold  in  1 each  slave ready/validOut/DataOut/hold.
- m_ready, m_rvalid, m_rdata  out  NM each  slave returns gated to owner bit; other bits 0.
- grant  out  NM  one-hot registered grant; all-zero when bus free.
- owner  out  OW  index of current/last owner; reset 0.
- bus_busy  out  1  high while in BUSY.
- timeout_err  out  1  one-cycle pulse when a grant is revoked by timeout.

## Operation
- States: IDLE, BUSY, TURN. Reset state IDLE.
- Round-robin pointer ptr (OW bits, reset 0) names the highest-priority master. Winner is the first set req bit scanning ptr, ptr+1, ..., wrapping modulo NM.
- IDLE: if any req bit is set, grant<=onehot(winner), owner<=winner, timer<=0, go to BUSY. Otherwise stay.
- BUSY: other req bits are ignored; no preemption.
  - If req[owner]=0: grant<=0, ptr<=(owner+1) mod NM, go to TURN.
  - Else if s_hold=0 and timer==TIMEOUT-1: grant<=0, ptr<=(owner+1) mod NM, timeout_err<=1 for one cycle, go to TURN.
  - Else timer<=timer+1 when s_hold=0. Timer holds its value when s_hold=1.
- TURN: one dead cycle with grant=0 so the slave returns to IDLE. Always go to IDLE.
- Mux and return gating are combinational from the registered grant. With grant=0, every s_* and m_* output is 0.
- Timer width: $clog2(TIMEOUT)+1; it never wraps.
- Simultaneous req drop and timeout on the same edge is a normal release: no timeout_err.
- A master re-raising req during TURN competes at the next IDLE edge, with ptr already advanced past it.
- A req pulse that is dropped before it is granted is lost. No queuing.
- Reset mid-transaction: grant, bus_busy, timeout_err, owner, ptr and timer go to 0 asynchronously; the mux outputs drop to 0 at once; state is IDLE.
- req bits for indices ≥NM do not exist. ptr wraps at NM-1 to 0, including for non-power-of-2 NM.

## Timing
- Grant latency: req sampled high in IDLE at edge k gives grant high after edge k.
  - Minimum latency is 1 cycle from req rising.
- Release: req[owner] low sampled at edge k gives grant low after edge k.
  - The next grant can appear after edge k+2 at the earliest.
  - grant is therefore all-zero for exactly 2 cycles between consecutive owners.
- Timeout: grant is removed after TIMEOUT non-hold cycles in BUSY. timeout_err is high in the same cycle grant falls.
- bus_busy equals (state==BUSY); it rises and falls with grant.
- Data paths have zero added latency. s_* follow m_*[owner] combinationally; m_ready/m_rvalid/m_rdata follow the slave combinationally.

## Test plan
- Reset: assert reset asynchronously mid-cycle with all inputs toggling. Required: grant=0, owner=0, bus_busy=0, timeout_err=0, and all s_*/m_* outputs 0 before the next edge.
- Single request: req=3'b010, m_addr[1] toggling. Required: grant=3'b010 and owner=1 one edge later; s_addr tracks m_addr[1]; m_ready[1]=s_ready while m_ready[0] and m_ready[2] stay 0. Drop req[1]: grant is 0 for 2 cycles and ptr becomes 2.
- Fairness: req=3'b111 held, each owner releases after 5 cycles. Required: grant sequence 001, 010, 100, 001, with a 2-cycle gap each time.
- Timeout (TIMEOUT=16): req[0] held for 40 cycles and req[2] also high. Required: grant[0] revoked after 16 BUSY cycles, a one-cycle timeout_err pulse, and grant=3'b100 two cycles later.
- Hold freeze (TIMEOUT=16): s_hold=1 for 10 cycles during master 0's grant. Required: revocation after 26 BUSY cycles.
- Release and timeout on the same edge: req[owner] falls exactly at timer==TIMEOUT-1. Required: normal release and timeout_err stays 0.
